mem_access_unit: RTL and testbench

Registered successor to the combinational memory transfer unit: a load/store engine between the MIPS core and an Avalon-MM data port. It accepts one request at a time, drives a stable bus transaction across waitrequest stalls, and formats all load results (sign/zero extension, LWL/LWR merge) and store byte lanes. It checks alignment and opcode validity, and aborts hung transfers with a bounded timeout.

---
 rtl/mem_access_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
//==============================================================================
// mem_access_unit : registered MIPS load/store engine for an Avalon-MM data port
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256,
  parameter int OP_W    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt_old,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest
);

  localparam int               CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  localparam logic [OP_W-1:0] OP_LB  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LWL = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LWR = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(10);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state, w_state_nx;
  logic [OP_W-1:0]   r_op, w_op_nx;
  logic [1:0]        r_k, w_k_nx;
  logic [31:0]       r_rt_old, w_rt_old_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;

  logic              w_busy_nx, w_resp_valid_nx, w_resp_err_nx;
  logic [31:0]       w_resp_data_nx;
  logic [ADDR_W-1:0] w_mem_address_nx;
  logic              w_mem_read_nx, w_mem_write_nx;
  logic [3:0]        w_mem_byteenable_nx;
  logic [31:0]       w_mem_writedata_nx;

  // Request decode, evaluated on the raw request inputs
  logic [1:0]  w_k;
  logic        w_is_load, w_is_store, w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_k        = req_addr[1:0];
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    w_wdata    = 32'h0;
    case (req_op)
      OP_LB, OP_LBU: begin
        w_is_load = 1'b1;
        w_be      = 4'b0001 << w_k;
      end
      OP_LH, OP_LHU: begin
        w_is_load  = 1'b1;
        w_misalign = w_k[0];
        w_be       = w_k[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        w_is_load  = 1'b1;
        w_misalign = (w_k != 2'd0);
        w_be       = 4'b1111;
      end
      OP_LWL, OP_LWR: begin
        w_is_load = 1'b1;
        w_be      = 4'b1111;
      end
      OP_SB: begin
        w_is_store = 1'b1;
        w_be       = 4'b0001 << w_k;
        w_wdata    = {24'h0, req_wdata[7:0]} << {w_k, 3'b000};
      end
      OP_SH: begin
        w_is_store = 1'b1;
        w_misalign = w_k[0];
        w_be       = w_k[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {16'h0, req_wdata[15:0]} << {w_k, 3'b000};
      end
      OP_SW: begin
        w_is_store = 1'b1;
        w_misalign = (w_k != 2'd0);
        w_be       = 4'b1111;
        w_wdata    = req_wdata;
      end
      default: ;
    endcase
  end

  // Load result formatting from the latched op/offset and live read data
  logic [31:0] w_shr, w_load_data, w_lwl_mask, w_lwr_mask;
  logic [15:0] w_half;

  always_comb begin
    w_shr  = mem_readdata >> {r_k, 3'b000};
    w_half = r_k[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    case (r_k)
      2'd0:    begin w_lwl_mask = 32'h00FF_FFFF; w_lwr_mask = 32'h0000_0000; end
      2'd1:    begin w_lwl_mask = 32'h0000_FFFF; w_lwr_mask = 32'hFF00_0000; end
      2'd2:    begin w_lwl_mask = 32'h0000_00FF; w_lwr_mask = 32'hFFFF_0000; end
      default: begin w_lwl_mask = 32'h0000_0000; w_lwr_mask = 32'hFFFF_FF00; end
    endcase
    case (r_op)
      OP_LB:   w_load_data = {{24{w_shr[7]}}, w_shr[7:0]};
      OP_LBU:  w_load_data = {24'h0, w_shr[7:0]};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'h0, w_half};
      OP_LW:   w_load_data = mem_readdata;
      OP_LWL:  w_load_data = (mem_readdata << {~r_k, 3'b000}) | (r_rt_old & w_lwl_mask);
      OP_LWR:  w_load_data = w_shr | (r_rt_old & w_lwr_mask);
      default: w_load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_k            <= 2'd0;
      r_rt_old       <= 32'h0;
      r_cnt          <= '0;
      busy           <= 1'b0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_data      <= 32'h0;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= 4'b0000;
      mem_writedata  <= 32'h0;
    end else begin
      r_state        <= w_state_nx;
      r_op           <= w_op_nx;
      r_k            <= w_k_nx;
      r_rt_old       <= w_rt_old_nx;
      r_cnt          <= w_cnt_nx;
      busy           <= w_busy_nx;
      resp_valid     <= w_resp_valid_nx;
      resp_err       <= w_resp_err_nx;
      resp_data      <= w_resp_data_nx;
      mem_address    <= w_mem_address_nx;
      mem_read       <= w_mem_read_nx;
      mem_write      <= w_mem_write_nx;
      mem_byteenable <= w_mem_byteenable_nx;
      mem_writedata  <= w_mem_writedata_nx;
    end
  end

  always_comb begin
    w_state_nx          = r_state;
    w_op_nx             = r_op;
    w_k_nx              = r_k;
    w_rt_old_nx         = r_rt_old;
    w_cnt_nx            = r_cnt;
    w_resp_valid_nx     = 1'b0;
    w_resp_err_nx       = 1'b0;
    w_resp_data_nx      = resp_data;
    w_mem_address_nx    = mem_address;
    w_mem_read_nx       = mem_read;
    w_mem_write_nx      = mem_write;
    w_mem_byteenable_nx = mem_byteenable;
    w_mem_writedata_nx  = mem_writedata;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_op_nx     = req_op;
          w_k_nx      = w_k;
          w_rt_old_nx = req_rt_old;
          if (!(w_is_load || w_is_store) || w_misalign) begin
            w_state_nx      = S_RESP;
            w_resp_valid_nx = 1'b1;
            w_resp_err_nx   = 1'b1;
            w_resp_data_nx  = 32'h0;
          end else begin
            w_state_nx          = S_ACCESS;
            w_cnt_nx            = '0;
            w_mem_address_nx    = {req_addr[ADDR_W-1:2], 2'b00};
            w_mem_read_nx       = w_is_load;
            w_mem_write_nx      = w_is_store;
            w_mem_byteenable_nx = w_be;
            w_mem_writedata_nx  = w_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (mem_waitrequest) begin
          // Abort on the TIMEOUT-th consecutive stall so the counter never wraps
          if (TO_EN && (r_cnt == CNT_LAST)) begin
            w_state_nx      = S_RESP;
            w_mem_read_nx   = 1'b0;
            w_mem_write_nx  = 1'b0;
            w_cnt_nx        = '0;
            w_resp_valid_nx = 1'b1;
            w_resp_err_nx   = 1'b1;
            w_resp_data_nx  = 32'h0;
          end else if (TO_EN) begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nx      = S_RESP;
          w_mem_read_nx   = 1'b0;
          w_mem_write_nx  = 1'b0;
          w_cnt_nx        = '0;
          w_resp_valid_nx = 1'b1;
          w_resp_data_nx  = w_load_data;
        end
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx     = S_IDLE;
        w_mem_read_nx  = 1'b0;
        w_mem_write_nx = 1'b0;
      end
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//==============================================================================
// tb_mem_access_unit : randomized and directed bench with a byte-level model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt_old;
  logic        busy, resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_waitrequest;

  int n_vec = 0;
  int n_err = 0;

  // observations from the last transaction
  int          o_lat, o_bus;
  logic        o_stable, o_hang, o_rd, o_wr, o_err, o_post_valid, o_post_busy;
  logic [31:0] o_addr, o_wd, o_data;
  logic [3:0]  o_be;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO), .OP_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .busy(busy), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
  );

  always #5 clk = ~clk;

  // Reference: MIPS little-endian semantics expressed lane by lane
  function automatic void model(input logic [3:0] op, input logic [31:0] addr, wdata, rt, rd,
                                output logic err, output logic ld, output logic [3:0] be,
                                output logic [31:0] wdo, output logic [31:0] data);
    int k, fl, n, v;
    logic [7:0] rb[4];
    logic [7:0] res[4];
    k = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) rb[i] = rd[8*i +: 8];
    err = 1'b0; ld = 1'b0; be = 4'b0; wdo = 32'h0; data = 32'h0; fl = 0; n = 0;
    case (op)
      4'd0, 4'd1: begin ld = 1'b1; fl = k; n = 1; end
      4'd2, 4'd3: begin ld = 1'b1; fl = k; n = 2; err = (k % 2) != 0; end
      4'd4:       begin ld = 1'b1; n = 4; err = (k != 0); end
      4'd5, 4'd6: begin ld = 1'b1; n = 4; end
      4'd8:       begin fl = k; n = 1; end
      4'd9:       begin fl = k; n = 2; err = (k % 2) != 0; end
      4'd10:      begin n = 4; err = (k != 0); end
      default:    err = 1'b1;
    endcase
    if (err) begin ld = 1'b0; return; end
    for (int i = 0; i < n; i++) be[fl+i] = 1'b1;
    if (!ld) begin
      for (int i = 0; i < n; i++) wdo[8*(fl+i) +: 8] = wdata[8*i +: 8];
      return;
    end
    case (op)
      4'd0, 4'd1: begin
        v = int'(rb[k]);
        if (op == 4'd0 && v >= 128) v -= 256;
        data = 32'(v);
      end
      4'd2, 4'd3: begin
        v = int'(rb[k]) + 256 * int'(rb[k+1]);
        if (op == 4'd2 && v >= 32768) v -= 65536;
        data = 32'(v);
      end
      4'd4: data = rd;
      default: begin
        for (int j = 0; j < 4; j++) begin
          if (op == 4'd5) begin
            if (j >= 3 - k) res[j] = rb[j-(3-k)]; else res[j] = rt[8*j +: 8];
          end else begin
            if (j <= 3 - k) res[j] = rb[j+k]; else res[j] = rt[8*j +: 8];
          end
        end
        data = {res[3], res[2], res[1], res[0]};
      end
    endcase
  endfunction

  // Drives one request and plays an Avalon slave inserting nwait stalls
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, wd, rt, rd, input int nwait);
    int left;
    left = nwait;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt_old = rt;
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_rt_old = $urandom;
    o_lat = 0; o_bus = 0; o_stable = 1'b1; o_hang = 1'b1; o_data = 32'h0; o_err = 1'b0;
    o_rd = 1'b0; o_wr = 1'b0; o_addr = 32'h0; o_be = 4'h0; o_wd = 32'h0;
    for (int c = 1; c <= 60; c++) begin
      if (mem_read || mem_write) begin
        if (o_bus == 0) begin
          o_rd = mem_read; o_wr = mem_write; o_addr = mem_address;
          o_be = mem_byteenable; o_wd = mem_writedata;
        end else if (o_rd !== mem_read || o_wr !== mem_write || o_addr !== mem_address ||
                     o_be !== mem_byteenable || o_wd !== mem_writedata) begin
          o_stable = 1'b0;
        end
        o_bus++;
        mem_waitrequest = (left > 0);
        if (left > 0) left--;
        mem_readdata = mem_waitrequest ? $urandom : rd;
      end else begin
        mem_waitrequest = 1'b0;
      end
      if (resp_valid) begin
        o_lat = c; o_data = resp_data; o_err = resp_err; o_hang = 1'b0;
        break;
      end
      @(negedge clk);
    end
    mem_waitrequest = 1'b0;
    @(negedge clk);
    o_post_valid = resp_valid;
    o_post_busy  = busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'h0;
    req_wdata = 32'h0; req_rt_old = 32'h0; mem_readdata = 32'h0; mem_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, resp_valid, resp_err, mem_read, mem_write} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {busy, resp_valid, resp_err, mem_read, mem_write});
    end
    n_vec++;
    if ({resp_data, mem_address, mem_writedata, mem_byteenable} !== 100'h0) begin
      n_err++; $display("FAIL reset_data: got %h/%h/%h/%b want zeros", resp_data, mem_address, mem_writedata, mem_byteenable);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_txn(4'd0, 32'h1003, 32'h0, 32'h0, 32'h80FF_0000, 0);
    n_vec++; if (o_data !== 32'hFFFF_FF80 || o_err !== 1'b0) begin n_err++; $display("FAIL lb_data: got %h err %b want ffffff80 err 0", o_data, o_err); end
    n_vec++; if (o_be !== 4'b1000 || o_addr !== 32'h1000 || o_rd !== 1'b1) begin n_err++; $display("FAIL lb_bus: got be %b addr %h rd %b want 1000 00001000 1", o_be, o_addr, o_rd); end
    n_vec++; if (o_lat !== 2) begin n_err++; $display("FAIL lb_latency: got %0d want 2", o_lat); end

    run_txn(4'd9, 32'h2002, 32'h1234_ABCD, 32'h0, 32'h0, 3);
    n_vec++; if (o_bus !== 4 || o_stable !== 1'b1 || o_wr !== 1'b1) begin n_err++; $display("FAIL sh_hold: got %0d cycles stable %b wr %b want 4 1 1", o_bus, o_stable, o_wr); end
    n_vec++; if (o_addr !== 32'h2000 || o_be !== 4'b1100 || o_wd !== 32'hABCD_0000) begin n_err++; $display("FAIL sh_bus: got %h %b %h want 00002000 1100 abcd0000", o_addr, o_be, o_wd); end
    n_vec++; if (o_lat !== 5 || o_data !== 32'h0) begin n_err++; $display("FAIL sh_resp: got lat %0d data %h want 5 0", o_lat, o_data); end

    run_txn(4'd5, 32'h3001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0);
    n_vec++; if (o_data !== 32'hCCDD_3344) begin n_err++; $display("FAIL lwl: got %h want ccdd3344", o_data); end
    run_txn(4'd6, 32'h3001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0);
    n_vec++; if (o_data !== 32'h11AA_BBCC) begin n_err++; $display("FAIL lwr: got %h want 11aabbcc", o_data); end
  endtask

  task automatic test_errors();
    run_txn(4'd4, 32'h4002, 32'h0, 32'h0, 32'h5555_5555, 0);
    n_vec++; if (o_bus !== 0 || o_err !== 1'b1 || o_lat !== 1 || o_data !== 32'h0) begin n_err++; $display("FAIL lw_misalign: got bus %0d err %b lat %0d data %h want 0 1 1 0", o_bus, o_err, o_lat, o_data); end
    run_txn(4'd7, 32'h4000, 32'h0, 32'h0, 32'h5555_5555, 0);
    n_vec++; if (o_bus !== 0 || o_err !== 1'b1 || o_lat !== 1 || o_post_busy !== 1'b0) begin n_err++; $display("FAIL bad_op: got bus %0d err %b lat %0d busy %b want 0 1 1 0", o_bus, o_err, o_lat, o_post_busy); end
  endtask

  task automatic test_timeout();
    run_txn(4'd4, 32'h5000, 32'h0, 32'h0, 32'h0, 1000);
    n_vec++; if (o_bus !== TO || o_err !== 1'b1 || o_lat !== TO + 1) begin n_err++; $display("FAIL timeout: got bus %0d err %b lat %0d want %0d 1 %0d", o_bus, o_err, o_lat, TO, TO + 1); end
    n_vec++; if (o_post_busy !== 1'b0 || o_post_valid !== 1'b0) begin n_err++; $display("FAIL timeout_idle: got busy %b valid %b want 0 0", o_post_busy, o_post_valid); end
    run_txn(4'd4, 32'h5004, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
    n_vec++; if (o_data !== 32'hDEAD_BEEF || o_err !== 1'b0 || o_lat !== 2) begin n_err++; $display("FAIL after_timeout: got %h err %b lat %0d want deadbeef 0 2", o_data, o_err, o_lat); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd4; req_addr = 32'h6000; mem_waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL mid_read_start: got %b want 1", mem_read); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (mem_read !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_async: got read %b busy %b want 0 0", mem_read, busy); end
    @(negedge clk);
    reset_n = 1'b1; mem_waitrequest = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid || busy) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_resp: got activity %b want 0", seen); end
  endtask

  task automatic test_random();
    logic [3:0] vops[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
    logic [3:0] op;
    logic [31:0] addr, wd, rt, rd, e_wd, e_data;
    logic e_err, e_ld;
    logic [3:0] e_be;
    int nw, e_lat;
    for (int t = 0; t < 200; t++) begin
      op = ($urandom_range(0, 9) < 8) ? vops[$urandom_range(0, 9)] : 4'($urandom_range(0, 15));
      addr = $urandom; wd = $urandom; rt = $urandom; rd = $urandom;
      nw = $urandom_range(0, TO - 1);
      model(op, addr, wd, rt, rd, e_err, e_ld, e_be, e_wd, e_data);
      e_lat = e_err ? 1 : 2 + nw;
      run_txn(op, addr, wd, rt, rd, nw);
      n_vec++;
      if (o_hang || o_lat !== e_lat || o_err !== e_err || o_data !== e_data) begin
        n_err++; $display("FAIL rand_resp op %0d addr %h: got lat %0d err %b data %h want %0d %b %h", op, addr, o_lat, o_err, o_data, e_lat, e_err, e_data);
      end
      n_vec++;
      if (o_post_valid !== 1'b0 || o_post_busy !== 1'b0) begin
        n_err++; $display("FAIL rand_idle op %0d: got valid %b busy %b want 0 0", op, o_post_valid, o_post_busy);
      end
      if (!e_err) begin
        n_vec++;
        if (o_bus !== nw + 1 || o_stable !== 1'b1 || o_rd !== e_ld || o_wr !== !e_ld ||
            o_addr !== {addr[31:2], 2'b00} || o_be !== e_be || (!e_ld && o_wd !== e_wd)) begin
          n_err++; $display("FAIL rand_bus op %0d addr %h: got n %0d st %b rw %b%b a %h be %b wd %h want n %0d be %b wd %h",
                            op, addr, o_bus, o_stable, o_rd, o_wr, o_addr, o_be, o_wd, nw + 1, e_be, e_wd);
        end
      end else begin
        n_vec++;
        if (o_bus !== 0) begin n_err++; $display("FAIL rand_err_bus op %0d addr %h: got %0d bus cycles want 0", op, addr, o_bus); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
